pxs_sync_gen: RTL and testbench
===============================

# pxs_sync_gen

VGA raster timing generator for the PixelStream pipeline: counts pixels and lines, then drives HSync, VSync, ActiveVideo, XCoord and YCoord as registered signals. It sits directly upstream of the stream-join stage, which packs these signals into the 26-bit VGA stream. An optional colour-bar generator also supplies the 1-bit Red/Green/Blue inputs of that stage.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low syncs)

Ports:
- clk  in  1  pixel-domain clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  pixel enable; the raster advances only on clk edges with ce=1
- HSync  out  1  horizontal sync, at level SYNC_POL when asserted
- VSync  out  1  vertical sync, at level SYNC_POL when asserted
- ActiveVideo  out  1  1 inside the visible window
- XCoord  out  10  horizontal counter value
- YCoord  out  10  vertical counter value
- FrameStart  out  1  one-clk pulse when (0,0) is presented
- Red, Green, Blue  out  1 each  colour-bar pattern (see Configuration)

## Operation
- Totals: HT = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and VT = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both totals must be ≤ 1024; violating this is a compile-time error.
  - H_ACTIVE must be a multiple of 8.
- Counters: hcnt and vcnt, 10 bits each. Counter value 0 is the first visible pixel/line.
- On each ce=1 edge:
  - hcnt increments, wrapping at HT-1 → 0.
  - On the hcnt wrap, vcnt increments, wrapping at VT-1 → 0.
- Decode from the current hcnt/vcnt, registered into the outputs on the same ce edge as the counter update:
  - XCoord = hcnt; YCoord = vcnt.
  - ActiveVideo = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - HSync asserted while H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - VSync asserted while V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (default 490..491).
  - VSync is decoded from vcnt only, so it changes on line boundaries.
- Coordinates are not cleared in blanking; they carry the raw counter values.
- ce=0: all counters and outputs hold, except FrameStart.

## Timing
- Reset (reset_n low), effective immediately:
  - hcnt = vcnt = 0.
  - HSync = VSync = ~SYNC_POL (deasserted).
  - ActiveVideo = 0, XCoord = YCoord = 0, FrameStart = 0, R/G/B = 0.
- Latency: outputs lag the counters by one ce edge.
  - The first ce edge after reset release presents (0,0) with ActiveVideo = 1.
- FrameStart:
  - High for exactly one clk cycle after the ce edge that loads (0,0).
  - Cleared on the next clk edge regardless of ce.
- Reset asserted mid-frame: immediate return to reset values. The raster restarts at (0,0) on the first ce after release; no partial-line recovery.
- Simultaneous wraps at (HT-1, VT-1): the next presented position is (0,0), and FrameStart fires.
- Period: HT·VT ce edges per frame; FrameStart pulses are exactly that many ce edges apart.

## Configuration
- Macro: PXS_SYNC_TESTPAT_EN.
- Defined: 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - A 3-bit bar index b is tracked with a bar counter (no divider).
  - Red = b[2], Green = b[1], Blue = b[0], registered with the other outputs.
  - All three are forced to 0 whenever ActiveVideo = 0.
- Not defined: Red, Green and Blue are tied to 0, and no bar logic is synthesised.

## Test plan
- Reset then continuous ce=1 -> first edge gives X=0, Y=0, ActiveVideo=1, FrameStart=1 for one clk; HSync stays 1 until X=656 and returns to 1 at X=752.
- Run one line -> ActiveVideo falls when X goes 639→640; at X=799 the next edge gives X=0, Y=1.
- Run to Y=490 -> VSync=0 for lines 490 and 491 only; after (799,524) comes (0,0) with FrameStart; frame length is 420000 ce edges.
- ce toggling 1/0 every cycle -> outputs change only on ce edges; frame length is 840000 clk cycles; FrameStart is still a single-clk pulse.
- Assert reset_n low at (300,200) -> outputs go to reset values asynchronously; restart at (0,0) after release.
- With PXS_SYNC_TESTPAT_EN defined:
  - X=79 -> RGB=000; X=80 -> RGB=001; X=639 -> RGB=111.
  - X=640 or Y=480 -> RGB=000.
  - Without the macro, RGB=000 everywhere.

Source files
------------

// File: rtl/pxs_sync_gen.sv
// VGA raster timing generator: registered HSync/VSync/ActiveVideo/coords, one ce edge behind the counters.
// Optional colour bars on Red/Green/Blue when PXS_SYNC_TESTPAT_EN is defined; otherwise they are tied low.
module pxs_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  output logic       HSync,
  output logic       VSync,
  output logic       ActiveVideo,
  output logic [9:0] XCoord,
  output logic [9:0] YCoord,
  output logic       FrameStart,
  output logic       Red,
  output logic       Green,
  output logic       Blue
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HT > 1024) begin : g_ht_chk
    $error("pxs_sync_gen: horizontal total exceeds 1024");
  end
  if (VT > 1024) begin : g_vt_chk
    $error("pxs_sync_gen: vertical total exceeds 1024");
  end
  if ((H_ACTIVE % 8) != 0) begin : g_bar_chk
    $error("pxs_sync_gen: H_ACTIVE must be a multiple of 8");
  end

  localparam logic        POL      = (SYNC_POL != 0);
  localparam logic [10:0] HT_M1    = 11'(HT - 1);
  localparam logic [10:0] VT_M1    = 11'(VT - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hcnt, vcnt;
  logic [10:0] hx, vy;
  logic        h_last, v_last;
  logic        act_d, hs_d, vs_d;

  // Widen by one bit so thresholds up to 1024 compare without truncation.
  assign hx     = {1'b0, hcnt};
  assign vy     = {1'b0, vcnt};
  assign h_last = (hx == HT_M1);
  assign v_last = (vy == VT_M1);
  assign act_d  = (hx < H_ACT) && (vy < V_ACT);
  assign hs_d   = (hx >= HS_START) && (hx < HS_END);
  assign vs_d   = (vy >= VS_START) && (vy < VS_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else if (ce) begin
      if (h_last) begin
        hcnt <= 10'd0;
        vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HSync       <= ~POL;
      VSync       <= ~POL;
      ActiveVideo <= 1'b0;
      XCoord      <= 10'd0;
      YCoord      <= 10'd0;
    end else if (ce) begin
      HSync       <= hs_d ? POL : ~POL;
      VSync       <= vs_d ? POL : ~POL;
      ActiveVideo <= act_d;
      XCoord      <= hcnt;
      YCoord      <= vcnt;
    end
  end

  // Pulse lasts one clk even when ce stays low afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= ce && (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

`ifdef PXS_SYNC_TESTPAT_EN
  localparam logic [9:0] BW_M1 = 10'((H_ACTIVE / 8) - 1);

  logic [9:0] bar_pix;
  logic [2:0] bar;

  // bar tracks hcnt: it is the bar index of the current counter position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_pix <= 10'd0;
      bar     <= 3'd0;
    end else if (ce) begin
      if (h_last) begin
        bar_pix <= 10'd0;
        bar     <= 3'd0;
      end else if (hx < H_ACT) begin
        if (bar_pix == BW_M1) begin
          bar_pix <= 10'd0;
          bar     <= bar + 3'd1;
        end else begin
          bar_pix <= bar_pix + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Red   <= 1'b0;
      Green <= 1'b0;
      Blue  <= 1'b0;
    end else if (ce) begin
      Red   <= act_d & bar[2];
      Green <= act_d & bar[1];
      Blue  <= act_d & bar[0];
    end
  end
`else
  assign Red   = 1'b0;
  assign Green = 1'b0;
  assign Blue  = 1'b0;
`endif

endmodule

// File: tb/tb_pxs_sync_gen.sv
// Bench for pxs_sync_gen on a reduced raster (48x12) so whole frames fit in a short run.
// Reference model tracks the presented raster position as a linear index; colour bars follow PXS_SYNC_TESTPAT_EN.
module tb_pxs_sync_gen;

  localparam int HA = 32, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 6,  VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam logic POL = 1'b0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       hsync, vsync, active_video, frame_start, red, green, blue;
  logic [9:0] xcoord, ycoord;

  int tests_run = 0;
  int tests_failed = 0;

  bit m_valid = 1'b0;
  bit m_fs = 1'b0;
  int m_pos = 0;
  int m_next = 0;
  int tick_no = 0;

  pxs_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .HSync(hsync), .VSync(vsync), .ActiveVideo(active_video),
    .XCoord(xcoord), .YCoord(ycoord), .FrameStart(frame_start),
    .Red(red), .Green(green), .Blue(blue)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] observed();
    return {hsync, vsync, active_video, xcoord, ycoord, frame_start, red, green, blue};
  endfunction

  function automatic logic [26:0] expected();
    int x, y;
    logic act, hs, vs;
    logic [2:0] rgb;
    if (!m_valid) return {~POL, ~POL, 1'b0, 10'd0, 10'd0, 1'b0, 3'b000};
    x   = m_pos % HT;
    y   = m_pos / HT;
    act = (x < HA) && (y < VA);
    hs  = (x >= HA + HFP) && (x < HA + HFP + HSW);
    vs  = (y >= VA + VFP) && (y < VA + VFP + VSW);
    rgb = 3'b000;
`ifdef PXS_SYNC_TESTPAT_EN
    if (act) rgb = 3'(x / (HA / 8));
`endif
    return {hs ? POL : ~POL, vs ? POL : ~POL, act, 10'(x), 10'(y), m_fs, rgb};
  endfunction

  // One clk cycle with the given ce, then advance the model.
  task automatic tick(input logic c);
    @(negedge clk);
    ce = c;
    @(posedge clk);
    #1;
    tick_no++;
    if (c) begin
      m_pos   = m_next;
      m_next  = (m_next + 1) % FT;
      m_valid = 1'b1;
      m_fs    = (m_pos == 0);
    end else begin
      m_fs = 1'b0;
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_fs    = 1'b0;
    m_pos   = 0;
    m_next  = 0;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (observed() !== expected()) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", observed(), expected());
    end
    @(negedge clk);
    ce = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL reset_hold_ce0 %0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_first_edge();
    tick(1'b1);
    tests_run++;
    if ({xcoord, ycoord, active_video, frame_start, hsync} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL first_edge: got x=%0d y=%0d av=%b fs=%b hs=%b expected 0 0 1 1 1",
               xcoord, ycoord, active_video, frame_start, hsync);
    end
    tick(1'b1);
    tests_run++;
    if (observed() !== expected()) begin
      tests_failed++;
      $display("FAIL second_edge: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_full_frame();
    int last_fs;
    int pulses;
    last_fs = -1;
    pulses = 0;
    for (int i = 0; i < 2 * FT + HT; i++) begin
      tick(1'b1);
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL full_frame tick %0d: got %h expected %h", tick_no, observed(), expected());
      end
      if (frame_start === 1'b1) begin
        pulses++;
        if (last_fs >= 0) begin
          tests_run++;
          if (tick_no - last_fs !== FT) begin
            tests_failed++;
            $display("FAIL frame_period: got %0d expected %0d", tick_no - last_fs, FT);
          end
        end
        last_fs = tick_no;
      end
    end
    tests_run++;
    if (pulses !== 2) begin
      tests_failed++;
      $display("FAIL frame_pulse_count: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_ce_toggle();
    int last_fs;
    int pulses;
    last_fs = -1;
    pulses = 0;
    for (int i = 0; i < 4 * FT + 8; i++) begin
      tick(logic'(i % 2 == 0));
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL ce_toggle tick %0d: got %h expected %h", tick_no, observed(), expected());
      end
      if (frame_start === 1'b1) begin
        pulses++;
        if (last_fs >= 0) begin
          tests_run++;
          if (tick_no - last_fs !== 2 * FT) begin
            tests_failed++;
            $display("FAIL ce_toggle_period: got %0d expected %0d", tick_no - last_fs, 2 * FT);
          end
        end
        last_fs = tick_no;
      end
    end
    tests_run++;
    if (pulses < 2) begin
      tests_failed++;
      $display("FAIL ce_toggle_pulses: got %0d expected at least 2", pulses);
    end
  endtask

  task automatic test_ce_random();
    for (int i = 0; i < 3 * FT; i++) begin
      tick(logic'($urandom_range(0, 1)));
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL ce_random tick %0d: got %h expected %h", tick_no, observed(), expected());
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(HT, FT - 1);
      for (int i = 0; i < n; i++) tick(1'b1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL reset_async %0d: got %h expected %h", k, observed(), expected());
      end
      @(negedge clk);
      ce = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 2 * HT; i++) begin
        tick(1'b1);
        tests_run++;
        if (observed() !== expected()) begin
          tests_failed++;
          $display("FAIL reset_restart %0d tick %0d: got %h expected %h", k, i, observed(), expected());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_full_frame();
    test_ce_toggle();
    test_ce_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
